cpu_prefetch: RTL and testbench

Instruction prefetch unit for the CPU core. It issues pipelined Wishbone B4 reads to the instruction port and keeps up to `Depth` requests in flight. Returned words, with their PCs, go into an in-order queue that feeds decode through a valid/ready handshake. Redirects from execute flush the queue, abort any bus cycle in progress, and restart fetch at the new word address.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/cpu_fifo.sv | 55 +++++
 rtl/cpu_prefetch.sv | 109 ++++++++++
 tb/tb_cpu_prefetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for the CPU instruction fetch path
package cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [29:0] waddr_t;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } prefetch_state_e;

    typedef struct packed {
        word_t  data;
        waddr_t pc;
        logic   err;
    } fetch_entry_t;

endpackage

// File: rtl/cpu_fifo.sv
// rtl/cpu_fifo.sv - synchronous power-of-two FIFO with a one-cycle flush
module cpu_fifo #(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    entry_t        mem_q [Depth];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

    // Full with simultaneous pop writes the slot being read; the old word is still presented this cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/cpu_prefetch.sv
// rtl/cpu_prefetch.sv - pipelined Wishbone instruction prefetcher feeding an in-order queue
module cpu_prefetch
    import cpu_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter waddr_t      ResetPc = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_data_s,
    input  logic        bus_ack,
    input  logic        bus_stall,
    input  logic        bus_err,
    output logic [31:0] bus_data_m,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [29:0] instr_pc,
    output logic        instr_err,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_pc
);

    localparam int unsigned CW = $clog2(Depth) + 1;

    prefetch_state_e state_q, state_d;
    waddr_t          fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   q_count;
    logic            q_empty;
    fetch_entry_t    q_wdata, q_rdata;
    logic            credit_ok, accept, resp, push, pop;

    // Credit covers both in-flight and queued words so the queue can never overflow.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, q_count}) < (CW+1)'(Depth);
    assign bus_stb   = !reset && (state_q == RUN) && credit_ok;
    assign bus_cyc   = bus_stb || (outstanding_q != '0);
    assign accept    = bus_stb && !bus_stall;
    assign resp      = (bus_ack || bus_err) && (outstanding_q != '0);
    assign push      = resp && !redirect_valid;
    assign pop       = !q_empty && instr_ready && !redirect_valid;

    // Requests are issued to consecutive addresses, so the oldest in flight is fetch_pc - outstanding.
    assign q_wdata = '{data: (bus_err ? word_t'(0) : bus_data_s),
                       pc:   fetch_pc_q - waddr_t'(outstanding_q),
                       err:  bus_err};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        if (redirect_valid) begin
            state_d       = FLUSH;
            fetch_pc_d    = redirect_pc;
            outstanding_d = '0;
        end else begin
            fetch_pc_d    = fetch_pc_q + waddr_t'(accept);
            outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
            case (state_q)
                RUN:     if (resp && bus_err) state_d = HALT;
                FLUSH:   state_d = RUN;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= ResetPc;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    cpu_fifo #(
        .Depth   (Depth),
        .entry_t (fetch_entry_t)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata (q_wdata),
        .pop   (pop),
        .rdata (q_rdata),
        .empty (q_empty),
        .count (q_count)
    );

    assign bus_addr    = fetch_pc_q;
    assign bus_data_m  = '0;
    assign bus_sel     = 4'hF;
    assign bus_we      = 1'b0;
    assign instr_valid = !q_empty;
    assign instr       = q_rdata.data;
    assign instr_pc    = q_rdata.pc;
    assign instr_err   = q_rdata.err;

endmodule

// File: tb/tb_cpu_prefetch.sv
// tb/tb_cpu_prefetch.sv - randomized self-checking bench for cpu_prefetch
module tb_cpu_prefetch;

    localparam int unsigned Depth   = 4;
    localparam logic [29:0] ResetPc = 30'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_data_s;
    logic        bus_ack, bus_stall, bus_err;
    logic [31:0] bus_data_m;
    logic [29:0] bus_addr;
    logic [3:0]  bus_sel;
    logic        bus_cyc, bus_stb, bus_we;
    logic        instr_valid;
    logic [31:0] instr;
    logic [29:0] instr_pc;
    logic        instr_err;
    logic        instr_ready, redirect_valid;
    logic [29:0] redirect_pc;

    int          tests = 0;
    int          fails = 0;
    logic [29:0] slv_q [$];
    logic [29:0] exp_pc;
    logic [29:0] err_addr = '0;
    logic [29:0] a0;
    bit          err_en = 0;
    bit          halted = 0;
    bit          seen_err = 0;
    int          pops = 0;
    int          n_acc = 0;
    int          cyc_no = 0;
    int          first_valid = -1;

    cpu_prefetch #(.Depth(Depth), .ResetPc(ResetPc)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_data_s     (bus_data_s),
        .bus_ack        (bus_ack),
        .bus_stall      (bus_stall),
        .bus_err        (bus_err),
        .bus_data_m     (bus_data_m),
        .bus_addr       (bus_addr),
        .bus_sel        (bus_sel),
        .bus_cyc        (bus_cyc),
        .bus_stb        (bus_stb),
        .bus_we         (bus_we),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_err      (instr_err),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Memory image seen by the slave, a fixed scramble of the word address.
    function automatic logic [31:0] memw(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hA5C3_0F1E ^ {2'b00, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ack_pct, input int stall_pct, input int rdy_pct);
        bus_stall   = ($urandom_range(99) < stall_pct);
        instr_ready = ($urandom_range(99) < rdy_pct);
        bus_ack     = 1'b0;
        bus_err     = 1'b0;
        bus_data_s  = '0;
        if (slv_q.size() > 0 && $urandom_range(99) < ack_pct) begin
            if (err_en && slv_q[0] == err_addr) begin
                bus_err = 1'b1;
            end else begin
                bus_ack    = 1'b1;
                bus_data_s = memw(slv_q[0]);
            end
        end
    endtask

    // Score the current cycle against the reference stream, then advance one clock.
    task automatic tick();
        bit h;
        bit e;
        h = 1'b0;
        if (halted) check("halt_no_stb", bus_stb, 0);
        check("inflight_cap", slv_q.size() <= Depth, 1);
        if (instr_valid && first_valid < 0) first_valid = cyc_no;
        if (instr_valid && instr_ready && !redirect_valid) begin
            e = err_en && (exp_pc == err_addr);
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, e ? 32'h0 : memw(exp_pc));
            check("instr_err", instr_err, e);
            if (e) seen_err = 1'b1;
            exp_pc = exp_pc + 30'd1;
            pops++;
        end
        if ((bus_ack || bus_err) && bus_cyc && slv_q.size() > 0) begin
            if (bus_err && !redirect_valid) h = 1'b1;
            void'(slv_q.pop_front());
        end
        if (bus_stb && !bus_stall && !redirect_valid) begin
            slv_q.push_back(bus_addr);
            n_acc++;
        end
        if (redirect_valid) begin
            slv_q.delete();
            exp_pc = redirect_pc;
            halted = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc_no++;
        if (h) halted = 1'b1;
    endtask

    // Redirect together with a stalled request, a pop and (if possible) an ack; then a stray ack in FLUSH.
    task automatic do_redirect(input logic [29:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        bus_stall      = 1'b1;
        instr_ready    = 1'b1;
        bus_err        = 1'b0;
        bus_ack        = 1'b0;
        bus_data_s     = '0;
        if (slv_q.size() > 0) begin
            bus_ack    = 1'b1;
            bus_data_s = memw(slv_q[0]);
        end
        tick();
        redirect_valid = 1'b0;
        bus_stall      = 1'b0;
        check("flush_cyc", bus_cyc, 0);
        check("flush_stb", bus_stb, 0);
        check("flush_valid", instr_valid, 0);
        bus_ack    = 1'b1;
        bus_data_s = 32'hDEAD_BEEF;
        tick();
        bus_ack = 1'b0;
        check("restart_stb", bus_stb, 1);
        check("restart_addr", bus_addr, pc);
        check("restart_valid", instr_valid, 0);
    endtask

    initial begin
        reset          = 1'b1;
        bus_data_s     = '0;
        bus_ack        = 1'b0;
        bus_stall      = 1'b0;
        bus_err        = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_pc         = ResetPc;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cyc", bus_cyc, 0);
        check("rst_stb", bus_stb, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_addr", bus_addr, ResetPc);
        check("const_sel", bus_sel, 4'hF);
        check("const_we", bus_we, 0);
        check("const_data_m", bus_data_m, 0);

        reset = 1'b0;
        #1;
        check("first_stb", bus_stb, 1);
        check("first_addr", bus_addr, ResetPc);

        // Zero-wait slave, decode always ready: one word per cycle after two cycles of latency.
        cyc_no = 0;
        pops   = 0;
        for (int i = 0; i < 20; i++) begin
            drive(100, 0, 100);
            tick();
        end
        check("stream_pops", pops, 18);
        check("first_valid_cycle", first_valid, 2);

        a0 = bus_addr;
        for (int i = 0; i < 3; i++) begin
            drive(100, 0, 100);
            bus_stall = 1'b1;
            check("stall_stb", bus_stb, 1);
            check("stall_addr", bus_addr, a0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(100, 0, 100);
            tick();
        end

        // Backpressure from an empty pipe: exactly Depth requests, then the bus idles.
        do_redirect(30'h40);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(100, 0, 0);
            tick();
        end
        check("bp_accepts", n_acc, Depth);
        check("bp_stb", bus_stb, 0);
        check("bp_cyc", bus_cyc, 0);
        check("bp_valid", instr_valid, 1);
        check("bp_head_pc", instr_pc, 30'h40);
        check("bp_next_addr", bus_addr, 30'h44);
        for (int i = 0; i < 10; i++) begin
            drive(100, 0, 100);
            tick();
        end

        // Build up unanswered requests, then redirect across the address wrap.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 100);
            tick();
        end
        do_redirect(30'h3FFF_FFFE);
        for (int i = 0; i < 12; i++) begin
            drive(100, 0, 100);
            tick();
        end
        check("wrap_progress", exp_pc, 30'h8);

        // Error completion halts issue; the already accepted word still arrives.
        err_en   = 1'b1;
        err_addr = 30'h204;
        seen_err = 1'b0;
        do_redirect(30'h200);
        for (int i = 0; i < 20; i++) begin
            drive(100, 0, 100);
            tick();
        end
        check("err_seen", seen_err, 1);
        check("err_last_pc", exp_pc, 30'h206);
        check("err_stb", bus_stb, 0);
        check("err_cyc", bus_cyc, 0);
        check("err_valid", instr_valid, 0);
        err_en = 1'b0;
        do_redirect(30'h300);
        for (int i = 0; i < 40; i++) begin
            drive(100, 0, 100);
            tick();
        end
        check("resume_progress", exp_pc, 30'h300 + 30'd38);

        // Random slave timing, decode backpressure and occasional redirects.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 3) begin
                do_redirect(30'($urandom()));
            end else begin
                drive(60, 30, 70);
                tick();
            end
        end
        for (int i = 0; i < 20; i++) begin
            drive(100, 0, 100);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
